// File: rtl/pkt_egress_scheduler.sv
// ---------------------------------------------------------------------------
// pkt_egress_scheduler
//   Shares one registered valid/ready egress port between PATH_COUNT routed
//   paths. Each path owns a small FIFO; a round-robin arbiter drains the
//   FIFOs one word per cycle into the output stage. Writes into a full FIFO
//   are dropped and reported with a one-cycle oDrop pulse.
//
//   Optional feature: define PKT_SCHED_DROPCNT_EN to add per-path saturating
//   drop counters on oDropCnt. Without it oDropCnt is tied to zero and no
//   counter flops are built.
// ---------------------------------------------------------------------------
module pkt_egress_scheduler #(
   parameter int PATH_COUNT = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            iClk,
   input  logic                            iRstN,
   input  logic                            iFlush,
   input  logic [PATH_COUNT-1:0]           iDataVld,
   input  logic [DATA_WIDTH-1:0]           iData,
   output logic                            oValid,
   output logic [DATA_WIDTH-1:0]           oData,
   output logic [$clog2(PATH_COUNT)-1:0]   oPath,
   input  logic                            iReady,
   output logic [PATH_COUNT-1:0]           oDrop,
   output logic [PATH_COUNT*CNT_WIDTH-1:0] oDropCnt
);

   localparam int PathW = $clog2(PATH_COUNT);
   localparam int PtrW  = $clog2(FIFO_DEPTH);
   localparam logic [PtrW:0] FullCount = FIFO_DEPTH[PtrW:0];

   typedef enum logic {
      IDLE  = 1'b0,
      VALID = 1'b1
   } schedStateT;

   // Per-path FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] fifoMem [PATH_COUNT][FIFO_DEPTH];
   logic [PtrW-1:0]       wrPtr   [PATH_COUNT];
   logic [PtrW-1:0]       rdPtr   [PATH_COUNT];
   logic [PtrW:0]         fillCnt [PATH_COUNT];

   logic [PATH_COUNT-1:0] notEmpty;
   logic [PATH_COUNT-1:0] isFull;
   logic [PATH_COUNT-1:0] pushEn;
   logic [PATH_COUNT-1:0] popVec;

   // Arbitration and output control
   logic [PathW-1:0] rrPtr;
   logic [PathW-1:0] grant;
   logic [PathW-1:0] grantNext;
   logic [PathW-1:0] cand;
   logic             grantVld;
   logic             popEn;
   schedStateT       state;
   schedStateT       stateNext;

   // FIFO status, taken from the count before the edge
   // NOTE: combinational blocks use blocking '=' and give every output a value
   // on every path through the block, so no latch can be inferred.
   always_comb begin
      notEmpty = '0;
      isFull   = '0;
      for (int i = 0; i < PATH_COUNT; i++) begin
         notEmpty[i] = (fillCnt[i] != '0);
         isFull[i]   = (fillCnt[i] == FullCount);
      end
   end

   // Round-robin search: first non-empty FIFO at or after rrPtr, modulo PATH_COUNT
   always_comb begin
      grant    = '0;
      grantVld = 1'b0;
      cand     = '0;
      for (int k = 0; k < PATH_COUNT; k++) begin
         if (int'(rrPtr) + k >= PATH_COUNT)
            cand = PathW'(int'(rrPtr) + k - PATH_COUNT);
         else
            cand = PathW'(int'(rrPtr) + k);
         if (!grantVld && notEmpty[cand]) begin
            grantVld = 1'b1;
            grant    = cand;
         end
      end
   end

   // Pointer value after a pop, wrapping the last path back to path 0
   always_comb begin
      grantNext = grant + 1'b1;
      if (grant == PathW'(PATH_COUNT - 1))
         grantNext = '0;
   end

   // Output FSM next-state and pop decision; flush forces IDLE with no pop
   always_comb begin
      stateNext = state;
      popEn     = 1'b0;
      if (iFlush) begin
         stateNext = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (grantVld) begin
                  popEn     = 1'b1;
                  stateNext = VALID;
               end
            end
            VALID: begin
               if (iReady) begin
                  if (grantVld)
                     popEn = 1'b1;
                  else
                     stateNext = IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // Per-path push/pop strobes; a full FIFO refuses the write even if popped this cycle
   always_comb begin
      pushEn = '0;
      popVec = '0;
      for (int i = 0; i < PATH_COUNT; i++) begin
         pushEn[i] = iDataVld[i] && !isFull[i] && !iFlush;
         popVec[i] = popEn && (grant == PathW'(i));
      end
   end

   // Output FSM state register
   // NOTE: clocked blocks use non-blocking '<=' so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)
         state <= IDLE;
      else
         state <= stateNext;
   end

   assign oValid = (state == VALID);

   // FIFO pointers and fill counts; flush empties every FIFO
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int i = 0; i < PATH_COUNT; i++) begin
            wrPtr[i]   <= '0;
            rdPtr[i]   <= '0;
            fillCnt[i] <= '0;
         end
      end else if (iFlush) begin
         for (int i = 0; i < PATH_COUNT; i++) begin
            wrPtr[i]   <= '0;
            rdPtr[i]   <= '0;
            fillCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < PATH_COUNT; i++) begin
            if (pushEn[i])
               wrPtr[i] <= wrPtr[i] + 1'b1;
            if (popVec[i])
               rdPtr[i] <= rdPtr[i] + 1'b1;
            case ({pushEn[i], popVec[i]})
               2'b10:   fillCnt[i] <= fillCnt[i] + 1'b1;
               2'b01:   fillCnt[i] <= fillCnt[i] - 1'b1;
               default: ;
            endcase
         end
      end
   end

   // FIFO storage write port
   // NOTE: the storage array has no reset; only pointers and counts need a
   // known value, and a slot is never read before it has been written.
   always_ff @(posedge iClk) begin
      for (int i = 0; i < PATH_COUNT; i++) begin
         if (pushEn[i])
            fifoMem[i][wrPtr[i]] <= iData;
      end
   end

   // Output word, source path and round-robin pointer, loaded on each pop
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oData <= '0;
         oPath <= '0;
         rrPtr <= '0;
      end else if (iFlush) begin
         oData <= '0;
         oPath <= '0;
         rrPtr <= '0;
      end else if (popEn) begin
         oData <= fifoMem[grant][rdPtr[grant]];
         oPath <= grant;
         rrPtr <= grantNext;
      end
   end

   // Drop pulse: a write that met a full FIFO, reported one cycle later
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN)
         oDrop <= '0;
      else if (iFlush)
         oDrop <= '0;
      else
         oDrop <= iDataVld & isFull;
   end

`ifdef PKT_SCHED_DROPCNT_EN
   logic [CNT_WIDTH-1:0] dropCnt [PATH_COUNT];

   // Saturating per-path drop counters; only reset clears them, flush does not
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int i = 0; i < PATH_COUNT; i++)
            dropCnt[i] <= '0;
      end else begin
         for (int i = 0; i < PATH_COUNT; i++) begin
            if (oDrop[i] && (dropCnt[i] != '1))
               dropCnt[i] <= dropCnt[i] + 1'b1;
         end
      end
   end

   // Pack the counters onto the flat output bus, path i at [i*CNT_WIDTH +: CNT_WIDTH]
   always_comb begin
      oDropCnt = '0;
      for (int i = 0; i < PATH_COUNT; i++)
         oDropCnt[i*CNT_WIDTH +: CNT_WIDTH] = dropCnt[i];
   end
`else
   assign oDropCnt = '0;
`endif

endmodule

// File: tb/tb_pkt_egress_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pkt_egress_scheduler
//   Directed scenarios followed by a randomized phase. A queue-based model
//   of the scheduler predicts the outputs after every clock edge. Counter
//   expectations follow PKT_SCHED_DROPCNT_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_pkt_egress_scheduler;

   localparam int PC      = 4;
   localparam int DW      = 8;
   localparam int FD      = 4;
   localparam int CW      = 3;
   localparam int PW      = $clog2(PC);
   localparam int CNT_MAX = (1 << CW) - 1;

   logic           iClk = 1'b0;
   logic           iRstN;
   logic           iFlush;
   logic [PC-1:0]  iDataVld;
   logic [DW-1:0]  iData;
   logic           iReady;
   logic           oValid;
   logic [DW-1:0]  oData;
   logic [PW-1:0]  oPath;
   logic [PC-1:0]  oDrop;
   logic [PC*CW-1:0] oDropCnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [DW-1:0] mQ [PC][$];
   logic          mValid;
   logic [DW-1:0] mData;
   int            mPath;
   int            mRr;
   logic [PC-1:0] mDrop;
   int            mCnt [PC];

   pkt_egress_scheduler #(
      .PATH_COUNT (PC),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (FD),
      .CNT_WIDTH  (CW)
   ) dut (
      .iClk     (iClk),
      .iRstN    (iRstN),
      .iFlush   (iFlush),
      .iDataVld (iDataVld),
      .iData    (iData),
      .oValid   (oValid),
      .oData    (oData),
      .oPath    (oPath),
      .iReady   (iReady),
      .oDrop    (oDrop),
      .oDropCnt (oDropCnt)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < PC; i++) begin
         mQ[i].delete();
         mCnt[i] = 0;
      end
      mValid = 1'b0;
      mData  = '0;
      mPath  = 0;
      mRr    = 0;
      mDrop  = '0;
   endtask

   // One clock edge of the scheduler, expressed with queues and the pre-edge contents
   task automatic model_edge();
      bit            full [PC];
      int            g;
      int            j;
      logic [PC-1:0] nd;
      // counters count the pulses visible before this edge
      for (int i = 0; i < PC; i++)
         if (mDrop[i] && mCnt[i] < CNT_MAX) mCnt[i]++;
      if (iFlush) begin
         for (int i = 0; i < PC; i++) mQ[i].delete();
         mValid = 1'b0;
         mData  = '0;
         mPath  = 0;
         mRr    = 0;
         mDrop  = '0;
         return;
      end
      for (int i = 0; i < PC; i++) full[i] = (mQ[i].size() == FD);
      if (!mValid || iReady) begin
         g = -1;
         for (int k = 0; k < PC; k++) begin
            j = (mRr + k) % PC;
            if (g < 0 && mQ[j].size() > 0) g = j;
         end
         if (g >= 0) begin
            mData  = mQ[g].pop_front();
            mPath  = g;
            mValid = 1'b1;
            mRr    = (g + 1) % PC;
         end else begin
            mValid = 1'b0;
         end
      end
      nd = '0;
      for (int i = 0; i < PC; i++) begin
         if (iDataVld[i]) begin
            if (full[i]) nd[i] = 1'b1;
            else mQ[i].push_back(iData);
         end
      end
      mDrop = nd;
   endtask

   task automatic compare_all();
      int expCnt;
      check("valid", 32'(oValid), 32'(mValid));
      if (mValid) begin
         check("data", 32'(oData), 32'(mData));
         check("path", 32'(oPath), 32'(mPath));
      end
      check("drop", 32'(oDrop), 32'(mDrop));
      for (int i = 0; i < PC; i++) begin
`ifdef PKT_SCHED_DROPCNT_EN
         expCnt = mCnt[i];
`else
         expCnt = 0;
`endif
         check("dropcnt", 32'(oDropCnt[i*CW +: CW]), 32'(expCnt));
      end
   endtask

   // Drive inputs, take one edge, advance the model, then compare #1 later
   task automatic tick(input logic [PC-1:0] vld, input logic [DW-1:0] d,
                       input logic rdy, input logic fl);
      iDataVld = vld;
      iData    = d;
      iReady   = rdy;
      iFlush   = fl;
      @(posedge iClk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      int expCnt0;
      int alt;
      iRstN    = 1'b0;
      iFlush   = 1'b0;
      iReady   = 1'b0;
      iDataVld = '0;
      iData    = '0;
      model_reset();
      repeat (2) @(posedge iClk);
      #1;
      check("rst_valid", 32'(oValid), 32'h0);
      check("rst_data", 32'(oData), 32'h0);
      check("rst_path", 32'(oPath), 32'h0);
      check("rst_drop", 32'(oDrop), 32'h0);
      check("rst_dropcnt", 32'(oDropCnt), 32'h0);
      iRstN = 1'b1;

      // T1: single word on path 0
      tick(4'b0001, 8'h05, 1'b1, 1'b0);
      check("t1_before", 32'(oValid), 32'h0);
      tick('0, '0, 1'b1, 1'b0);
      check("t1_valid", 32'(oValid), 32'h1);
      check("t1_data", 32'(oData), 32'h05);
      check("t1_path", 32'(oPath), 32'h0);
      tick('0, '0, 1'b1, 1'b0);
      check("t1_idle", 32'(oValid), 32'h0);

      // T2: words queued on p1, p3, p2 drain in path order
      tick(4'b0010, 8'h15, 1'b0, 1'b0);
      tick(4'b1000, 8'h35, 1'b0, 1'b0);
      check("t2_first", 32'(oData), 32'h15);
      check("t2_first_path", 32'(oPath), 32'h1);
      tick(4'b0100, 8'h25, 1'b0, 1'b0);
      check("t2_hold", 32'(oData), 32'h15);
      tick('0, '0, 1'b1, 1'b0);
      check("t2_second", 32'(oData), 32'h25);
      check("t2_second_path", 32'(oPath), 32'h2);
      tick('0, '0, 1'b1, 1'b0);
      check("t2_third", 32'(oData), 32'h35);
      check("t2_third_path", 32'(oPath), 32'h3);
      tick('0, '0, 1'b1, 1'b0);
      check("t2_idle", 32'(oValid), 32'h0);
      // pointer back at 0: a broadcast to p0/p1 must emerge p0 first
      tick(4'b0011, 8'h44, 1'b1, 1'b0);
      tick('0, '0, 1'b1, 1'b0);
      check("t2_rr0", 32'(oPath), 32'h0);
      tick('0, '0, 1'b1, 1'b0);
      check("t2_rr1", 32'(oPath), 32'h1);
      tick('0, '0, 1'b1, 1'b0);

      // T3/T4: output stage holds p1 word; p0 overfills and drops twice
      tick(4'b0010, 8'hA1, 1'b0, 1'b0);
      check("t3_empty", 32'(oValid), 32'h0);
      tick(4'b0001, 8'h00, 1'b0, 1'b0);
      check("t3_head", 32'(oData), 32'hA1);
      for (int v = 1; v <= 5; v++) begin
         tick(4'b0001, 8'(v), 1'b0, 1'b0);
         check("t3_drop", 32'(oDrop), (v >= 4) ? 32'h1 : 32'h0);
      end
      for (int c = 0; c < 10; c++) begin
         tick('0, '0, 1'b0, 1'b0);
         check("t4_hold_valid", 32'(oValid), 32'h1);
         check("t4_hold_data", 32'(oData), 32'hA1);
         check("t4_hold_path", 32'(oPath), 32'h1);
      end
`ifdef PKT_SCHED_DROPCNT_EN
      expCnt0 = 2;
`else
      expCnt0 = 0;
`endif
      check("t3_dropcnt", 32'(oDropCnt[CW-1:0]), 32'(expCnt0));
      for (int k = 0; k < 4; k++) begin
         tick('0, '0, 1'b1, 1'b0);
         check("t4_drain_valid", 32'(oValid), 32'h1);
         check("t4_drain_data", 32'(oData), 32'(k));
         check("t4_drain_path", 32'(oPath), 32'h0);
      end
      tick('0, '0, 1'b1, 1'b0);
      check("t4_idle", 32'(oValid), 32'h0);

      // T5: p0 and p2 written every cycle; grants alternate starting at p2
      alt = 2;
      for (int c = 0; c < 12; c++) begin
         tick(4'b0101, 8'(8'h60 + c), 1'b1, 1'b0);
         if (c >= 1) begin
            check("t5_alt", 32'(oPath), 32'(alt));
            alt = (alt == 0) ? 2 : 0;
         end
      end
      for (int c = 0; c < 12; c++) tick('0, '0, 1'b1, 1'b0);
      check("t5_idle", 32'(oValid), 32'h0);

      // T6: flush with three words in flight, then a p3 word
      tick(4'b0001, 8'h11, 1'b0, 1'b0);
      tick(4'b0010, 8'h22, 1'b0, 1'b0);
      tick(4'b0100, 8'h33, 1'b0, 1'b0);
      check("t6_busy", 32'(oValid), 32'h1);
      tick('0, '0, 1'b0, 1'b1);
      check("t6_flush_valid", 32'(oValid), 32'h0);
      check("t6_flush_drop", 32'(oDrop), 32'h0);
      tick('0, '0, 1'b1, 1'b0);
      check("t6_empty", 32'(oValid), 32'h0);
      tick(4'b1000, 8'h77, 1'b1, 1'b0);
      tick('0, '0, 1'b1, 1'b0);
      check("t6_valid", 32'(oValid), 32'h1);
      check("t6_data", 32'(oData), 32'h77);
      check("t6_path", 32'(oPath), 32'h3);
      tick('0, '0, 1'b1, 1'b0);

      // Randomized traffic with back-pressure and occasional flush
      for (int n = 0; n < 600; n++) begin
         tick(($urandom_range(0, 2) != 0) ? PC'($urandom) : '0, DW'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
      end

      // Asynchronous reset in the middle of a transfer
      tick(4'b1111, 8'hC3, 1'b0, 1'b0);
      tick(4'b1111, 8'hC4, 1'b0, 1'b0);
      iDataVld = '0;
      iReady   = 1'b0;
      iRstN    = 1'b0;
      #2;
      model_reset();
      check("arst_valid", 32'(oValid), 32'h0);
      check("arst_data", 32'(oData), 32'h0);
      check("arst_dropcnt", 32'(oDropCnt), 32'h0);
      compare_all();
      @(posedge iClk);
      #1;
      iRstN = 1'b1;
      tick(4'b0100, 8'h5A, 1'b1, 1'b0);
      tick('0, '0, 1'b1, 1'b0);
      check("arst_after_data", 32'(oData), 32'h5A);
      check("arst_after_path", 32'(oPath), 32'h2);
      tick('0, '0, 1'b1, 1'b0);
      check("arst_after_idle", 32'(oValid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
